output_argmax: RTL
==================

# output_argmax

Downstream classification stage for the digit network. It accepts the output-layer activations as a stream of signed fixed-point scores, one beat per class, and tracks the running maximum. When a frame is complete it presents the winning class index and its score through a valid/ready handshake. Its result drives the Basys3 display and LED logic.

## Interface
- `NUM_CLASSES`, 10, output-layer width; must be ≥ 2
- `DATA_W`, 32, score width, signed two's complement (Q16.16)
- `IDX_W`, 4, class index width; must satisfy 2^IDX_W ≥ `NUM_CLASSES`
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `s_valid`  in  1  score beat valid
- `s_ready`  out  1  stage can accept a score beat
- `s_data`  in  `DATA_W`  signed score, class order 0..`NUM_CLASSES`-1
- `s_last`  in  1  final beat of frame
- `m_valid`  out  1  result valid
- `m_ready`  in  1  consumer accepts result
- `m_class`  out  `IDX_W`  winning class index
- `m_score`  out  `DATA_W`  winning score
- `m_err`  out  1  frame length ≠ `NUM_CLASSES`
- `m_margin`  out  `DATA_W`  unsigned best minus second-best score (see Configuration)

## Operation
- FSM states:
  - `COLLECT`: `s_ready`=1, `m_valid`=0.
  - `HOLD`: `s_ready`=0, `m_valid`=1.
- A beat transfers when `s_valid & s_ready`.
- Counter `cnt` (`IDX_W`+1 bits) counts the beats transferred in the current frame and saturates at `NUM_CLASSES`.
- First beat of a frame (`cnt`=0): best ← `s_data`, best_idx ← 0.
- Later beats: signed compare. best is replaced only when `s_data` > best (strict). Ties keep the lower index.
- Beats arriving when `cnt` ≥ `NUM_CLASSES` are consumed and ignored for the argmax. They set err_flag.
- Transfer with `s_last`=1:
  - err_flag is set if the beat's index ≠ `NUM_CLASSES`-1.
  - Results and err are latched into the output registers.
  - `cnt` and err_flag clear, and the FSM moves to `HOLD`.
- A frame without `s_last` never completes; it keeps absorbing beats.
- `HOLD` → `COLLECT` on `m_ready`=1. Outputs stay stable while waiting.
- Reset values:
  - FSM = `COLLECT`; `s_ready` = 0 while `rst_n` = 0 and 1 from the first cycle after release.
  - `m_valid` = 0, `m_class` = 0, `m_score` = 0, `m_err` = 0, `m_margin` = 0.
  - `cnt`, best and err_flag are cleared.
- Reset mid-frame discards the partial frame. Reset in `HOLD` drops the pending result.

## Timing
- `m_valid` rises the cycle after the `s_last` transfer (1-cycle latency).
- No overlap between frames: `s_ready`=0 throughout `HOLD`.
- Minimum frame period is `NUM_CLASSES`+1 cycles with `m_ready` held at 1.
- The result handshake completes on the edge where `m_valid & m_ready`. `s_ready`=1 on the next cycle.
- `s_ready` is a pure function of the FSM state. It does not combinationally depend on `s_valid` or `m_ready`.
- Comparator and update fit in one cycle at 100 MHz. No pipelining inside a frame.

## Configuration
- `ARGMAX_MARGIN_EN` defined:
  - The stage also tracks a second-best score.
  - When the new beat beats best (strict), second ← old best. Otherwise, when it beats second (strict), second ← new beat. The first beat initialises second to the most-negative value.
  - `m_margin` = best − second, as a `DATA_W`-bit unsigned value (never negative), latched with the result.
  - Beats at index ≥ `NUM_CLASSES` are excluded.
- Not defined: no second-best register; `m_margin` is tied to 0.

## Test plan
- 10-beat frame with scores 0x0000_1000 × 10, except class 7 = 0x0003_0000 → `m_class`=7, `m_score`=0x0003_0000, `m_err`=0, `m_valid` one cycle after last; with `ARGMAX_MARGIN_EN`, `m_margin`=0x0002_F000.
- Negative scores (all −0x0001_0000, class 2 = −0x0000_8000) → `m_class`=2, confirming the signed compare.
- Tie: classes 3 and 8 both 0x0005_0000 (maximum) → `m_class`=3; `m_margin`=0 when enabled.
- Length errors:
  - `s_last` on beat 6 → `m_err`=1, argmax over beats 0–6.
  - 12 beats with `s_last` on beat 11 → `m_err`=1, beats 10–11 ignored.
- Backpressure:
  - `m_ready` held 0 for 20 cycles → `m_valid`, `m_class` and `m_score` stay stable, `s_ready`=0; one cycle after `m_ready`=1, `s_ready`=1.
  - Back-to-back frames with `m_ready`=1 → 11-cycle period.
- `rst_n`=0 asserted after 5 beats → all outputs 0. A following full frame with class 0 maximum → `m_class`=0, `m_err`=0.

Source files
------------

// File: rtl/output_argmax_if.sv
// Handshake bundle for output_argmax: score stream in, winning-class result out.
// The master drives scores and accepts results; the slave is the argmax stage.
interface output_argmax_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [IDX_W-1:0]  m_class;
    logic [DATA_W-1:0] m_score;
    logic              m_err;
    logic [DATA_W-1:0] m_margin;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class, m_score, m_err, m_margin
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class, m_score, m_err, m_margin
    );
endinterface

// File: rtl/output_argmax.sv
// Streaming argmax over one frame of signed Q16.16 class scores, result held until accepted.
// Define ARGMAX_MARGIN_EN to also track the second-best score and report best minus second.
//
// state   | meaning
// COLLECT | accepting score beats, tracking the running maximum
// HOLD    | result presented on m_*, score stream stalled until m_ready
module output_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    output_argmax_if.slave bus
);
    typedef enum logic {COLLECT, HOLD} state_e;

    localparam logic [IDX_W:0]    CNT_MAX  = (IDX_W+1)'(NUM_CLASSES);
    localparam logic [IDX_W:0]    LAST_IDX = (IDX_W+1)'(NUM_CLASSES - 1);
    localparam logic [IDX_W:0]    CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_e                    state_q;
    logic                      s_ready_q, m_valid_q;
    logic [IDX_W:0]            cnt_q;
    logic signed [DATA_W-1:0]  best_q, best_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;
    logic                      err_q, err_d;
    logic [IDX_W-1:0]          m_class_q;
    logic [DATA_W-1:0]         m_score_q;
    logic                      m_err_q;
    logic signed [DATA_W-1:0]  s_data_s;
    logic                      beat, in_range, first;

    assign s_data_s = bus.s_data;
    assign beat     = bus.s_valid & s_ready_q;
    assign in_range = cnt_q < CNT_MAX;
    assign first    = cnt_q == '0;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0] second_q, second_d;
    logic [DATA_W-1:0]        m_margin_q;
    assign bus.m_margin = m_margin_q;
`else
    assign bus.m_margin = '0;
`endif

    // Running update including the current beat; used both to advance and to latch the result.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        err_d      = err_q;
`ifdef ARGMAX_MARGIN_EN
        second_d   = second_q;
`endif
        if (!in_range) begin
            err_d = 1'b1;
        end else if (first) begin
            best_d     = s_data_s;
            best_idx_d = '0;
`ifdef ARGMAX_MARGIN_EN
            second_d   = MOST_NEG;
`endif
        end else if (s_data_s > best_q) begin
            best_d     = s_data_s;
            best_idx_d = cnt_q[IDX_W-1:0];
`ifdef ARGMAX_MARGIN_EN
            second_d   = best_q;
        end else if (s_data_s > second_q) begin
            second_d   = s_data_s;
`endif
        end
        if (bus.s_last && (cnt_q != LAST_IDX)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            err_q      <= 1'b0;
            m_class_q  <= '0;
            m_score_q  <= '0;
            m_err_q    <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= '0;
            m_margin_q <= '0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    s_ready_q <= 1'b1;
                    if (beat && bus.s_last) begin
                        state_q   <= HOLD;
                        s_ready_q <= 1'b0;
                        m_valid_q <= 1'b1;
                        m_class_q <= best_idx_d;
                        m_score_q <= best_d;
                        m_err_q   <= err_d;
`ifdef ARGMAX_MARGIN_EN
                        m_margin_q <= best_d - second_d;
`endif
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                    end else if (beat) begin
                        cnt_q      <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                        best_q     <= best_d;
                        best_idx_q <= best_idx_d;
                        err_q      <= err_d;
`ifdef ARGMAX_MARGIN_EN
                        second_q   <= second_d;
`endif
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        state_q   <= COLLECT;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_class = m_class_q;
    assign bus.m_score = m_score_q;
    assign bus.m_err   = m_err_q;
endmodule
